// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD job scheduler: FSM states,
// requester count, operand and timeout-counter widths.
package gcd_pkg;

   localparam int NREQ  = 4;
   localparam int OP_W  = 8;
   localparam int TMO_W = 10;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      REL,
      BYP,
      RESP
   } state_t;

   function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/gcd_sched_if.sv
// Requester and engine signals of the GCD scheduler. The scheduler itself
// uses the slave view; the surrounding requesters/engine use the master view.
interface gcd_sched_if;
   import gcd_pkg::*;

   logic [NREQ-1:0]      req;
   logic [NREQ*OP_W-1:0] req_p;
   logic [NREQ*OP_W-1:0] req_q;
   logic [NREQ-1:0]      ack;
   logic [OP_W-1:0]      res;
   logic                 res_err;
   logic [NREQ-1:0]      res_valid;
   logic                 busy;
   logic                 eng_start;
   logic [OP_W-1:0]      eng_p;
   logic [OP_W-1:0]      eng_q;
   logic [OP_W-1:0]      eng_r;
   logic                 eng_done;
   logic                 eng_abort;

   modport slave (
      input  req, req_p, req_q, eng_r, eng_done,
      output ack, res, res_err, res_valid, busy, eng_start, eng_p, eng_q, eng_abort
   );

   modport master (
      output req, req_p, req_q, eng_r, eng_done,
      input  ack, res, res_err, res_valid, busy, eng_start, eng_p, eng_q, eng_abort
   );

endinterface

// File: rtl/rr_arb4.sv
// Four-way round-robin selector: the first active request at or after ptr
// (wrapping) wins. Purely combinational.
module rr_arb4
   import gcd_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   output logic [NREQ-1:0] grant,
   output logic [1:0]      idx,
   output logic            any
);

   logic [NREQ-1:0] rot;
   logic [1:0]      off;

   // rot[k] is the requester k places after ptr
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_rot
         assign rot[gi] = req[2'(ptr + 2'(gi))];
      end
   endgenerate

   always_comb begin
      off = 2'd0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = 2'(i);
         end
      end
   end

   assign any   = |req;
   assign idx   = ptr + off;
   assign grant = any ? onehot(idx) : '0;

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler that serialises GCD jobs from four requesters onto one
// external engine, with a zero-operand bypass and an engine-hang timeout.
module gcd_sched #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1023
) (
   input logic        clk,
   input logic        rst,
   gcd_sched_if.slave bus
);
   import gcd_pkg::state_t;
   import gcd_pkg::IDLE;
   import gcd_pkg::RUN;
   import gcd_pkg::REL;
   import gcd_pkg::BYP;
   import gcd_pkg::RESP;
   import gcd_pkg::OP_W;
   import gcd_pkg::TMO_W;
   import gcd_pkg::onehot;

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_t          state_reg, state_next;
   logic [1:0]      ptr_reg, owner_reg;
   logic [OP_W-1:0] op_p_reg, op_q_reg, res_reg;
   logic            err_reg;
   logic [TMO_W-1:0] tmo_cnt_reg;
   logic [NREQ-1:0] ack_reg, res_valid_reg;

   logic [NREQ-1:0] arb_grant;
   logic [1:0]      arb_idx;
   logic            arb_any;
   logic [OP_W-1:0] p_arr [NREQ];
   logic [OP_W-1:0] q_arr [NREQ];
   logic [OP_W-1:0] sel_p, sel_q;
   logic            tmo_hit, eng_start_c, eng_abort_c, busy_c;

   rr_arb4 u_arb (
      .req   (bus.req),
      .ptr   (ptr_reg),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_ops
         assign p_arr[gi] = bus.req_p[gi*OP_W +: OP_W];
         assign q_arr[gi] = bus.req_q[gi*OP_W +: OP_W];
      end
   endgenerate

   assign sel_p = p_arr[arb_idx];
   assign sel_q = q_arr[arb_idx];

   always_comb begin
      state_next  = state_reg;
      eng_start_c = 1'b0;
      eng_abort_c = 1'b0;
      busy_c      = (state_reg != IDLE);
      tmo_hit     = (tmo_cnt_reg == TMO_LAST);
      case (state_reg)
         IDLE: begin
            if (arb_any) begin
               state_next = (sel_p == '0 || sel_q == '0) ? BYP : RUN;
            end
         end
         RUN: begin
            eng_start_c = 1'b1;
            if (bus.eng_done) begin
               state_next = REL;
            end else if (tmo_hit) begin
               eng_abort_c = 1'b1;
               state_next  = REL;
            end
         end
         // 4-phase return: engine must drop done before the next job may start
         REL: begin
            if (!bus.eng_done) begin
               state_next = RESP;
            end
         end
         BYP:     state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         ptr_reg       <= 2'd0;
         owner_reg     <= 2'd0;
         op_p_reg      <= '0;
         op_q_reg      <= '0;
         res_reg       <= '0;
         err_reg       <= 1'b0;
         tmo_cnt_reg   <= '0;
         ack_reg       <= '0;
         res_valid_reg <= '0;
      end else begin
         state_reg     <= state_next;
         ack_reg       <= '0;
         res_valid_reg <= '0;
         case (state_reg)
            IDLE: begin
               if (arb_any) begin
                  ack_reg     <= arb_grant;
                  owner_reg   <= arb_idx;
                  op_p_reg    <= sel_p;
                  op_q_reg    <= sel_q;
                  ptr_reg     <= arb_idx + 2'd1;
                  tmo_cnt_reg <= '0;
                  err_reg     <= 1'b0;
               end
            end
            RUN: begin
               tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
               if (bus.eng_done) begin
                  res_reg <= bus.eng_r;
               end else if (tmo_hit) begin
                  res_reg <= '0;
                  err_reg <= 1'b1;
               end
            end
            // gcd(0,x)=x and gcd(0,0)=0 both reduce to a bitwise OR
            BYP:  res_reg       <= op_p_reg | op_q_reg;
            RESP: res_valid_reg <= onehot(owner_reg);
            default: ;
         endcase
      end
   end

   assign bus.ack       = ack_reg;
   assign bus.res       = res_reg;
   assign bus.res_err   = err_reg;
   assign bus.res_valid = res_valid_reg;
   assign bus.busy      = busy_c;
   assign bus.eng_start = eng_start_c;
   assign bus.eng_abort = eng_abort_c;
   assign bus.eng_p     = (state_reg == RUN) ? op_p_reg : '0;
   assign bus.eng_q     = (state_reg == RUN) ? op_q_reg : '0;

endmodule

// File: tb/tb_gcd_sched.sv
// Self-checking bench for gcd_sched: directed vector table, contention and
// corner sequences, then random batches checked against an arithmetic model.
module tb_gcd_sched;

   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gcd_sched_if bus ();

   gcd_sched #(.NREQ(4), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int mptr   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int ref_gcd(input int a_in, input int b_in);
      int a, b, t;
      a = a_in;
      b = b_in;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int rr_pick(input logic [3:0] pend, input int ptr);
      for (int o = 0; o < 4; o++) begin
         if (pend[(ptr + o) % 4]) return (ptr + o) % 4;
      end
      return -1;
   endfunction

   // external engine: answers after eng_lat cycles, holds done eng_stale extra cycles
   int         eng_lat    = 2;
   int         eng_stale  = 0;
   bit         eng_hang   = 1'b0;
   bit         force_done = 1'b0;
   logic       done_m     = 1'b0;
   logic [7:0] r_m        = 8'd0;
   int         cnt_m      = 0;
   int         hold_m     = 0;

   always @(posedge clk) begin
      if (rst || bus.eng_abort) begin
         done_m <= 1'b0;
         cnt_m  <= 0;
         hold_m <= 0;
      end else if (bus.eng_start && !done_m) begin
         if (!eng_hang) begin
            if (cnt_m >= eng_lat) begin
               done_m <= 1'b1;
               r_m    <= 8'(ref_gcd(int'(bus.eng_p), int'(bus.eng_q)));
               cnt_m  <= 0;
            end else begin
               cnt_m <= cnt_m + 1;
            end
         end
      end else if (!bus.eng_start && done_m) begin
         if (hold_m >= eng_stale) begin
            done_m <= 1'b0;
            hold_m <= 0;
         end else begin
            hold_m <= hold_m + 1;
         end
      end
   end

   assign bus.eng_done = done_m | force_done;
   assign bus.eng_r    = r_m;

   task automatic do_job(input int idx, input logic [7:0] p, input logic [7:0] q,
                         output int ack_lat, output int rv_lat, output logic [3:0] rv_mask,
                         output logic [7:0] r, output logic e, output int abort_at, output int starts);
      ack_lat  = -1;
      rv_lat   = -1;
      rv_mask  = 4'd0;
      r        = 8'd0;
      e        = 1'b0;
      abort_at = -1;
      starts   = 0;
      bus.req_p[idx*8 +: 8] = p;
      bus.req_q[idx*8 +: 8] = q;
      bus.req = 4'b0001 << idx;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (ack_lat < 0 && bus.ack != 4'd0) begin
            ack_lat = (bus.ack == (4'b0001 << idx)) ? k : -2;
            bus.req = 4'd0;
         end
         if (bus.eng_start) starts++;
         if (bus.eng_abort && abort_at < 0) abort_at = k;
         if (bus.res_valid != 4'd0) begin
            rv_lat  = k;
            rv_mask = bus.res_valid;
            r       = bus.res;
            e       = bus.res_err;
            break;
         end
      end
      bus.req = 4'd0;
      mptr = (idx + 1) % 4;
      $display("job req%0d P=%0d Q=%0d -> res=%0d err=%0d ack@%0d rv@%0d", idx, p, q, r, e, ack_lat, rv_lat);
   endtask

   int served_idx[$];
   int served_res[$];

   task automatic run_batch(input logic [3:0] mask, input logic [7:0] p[4], input logic [7:0] q[4], input string tag);
      logic [3:0] pending;
      int         exp_g[$];
      int         g;
      int         viol;
      bit         byp_cur;
      served_idx.delete();
      served_res.delete();
      for (int i = 0; i < 4; i++) begin
         bus.req_p[i*8 +: 8] = p[i];
         bus.req_q[i*8 +: 8] = q[i];
      end
      pending = mask;
      viol    = 0;
      byp_cur = 1'b0;
      bus.req = mask;
      for (int guard = 0; guard < 400 && (pending != 4'd0 || exp_g.size() != 0); guard++) begin
         @(posedge clk); #1;
         if (bus.ack != 4'd0) begin
            g = rr_pick(pending, mptr);
            chk({tag, " grant"}, bus.ack, (g < 0) ? 32'd0 : (32'd1 << g));
            bus.req = bus.req & ~bus.ack;
            if (g >= 0) begin
               pending[g] = 1'b0;
               mptr = (g + 1) % 4;
               exp_g.push_back(g);
               byp_cur = (p[g] == 8'd0 || q[g] == 8'd0);
            end
         end
         if (bus.eng_start && byp_cur) viol++;
         if (bus.res_valid != 4'd0) begin
            if (exp_g.size() == 0) begin
               chk({tag, " unexpected res_valid"}, bus.res_valid, 0);
            end else begin
               g = exp_g.pop_front();
               chk({tag, " rv owner"}, bus.res_valid, 32'd1 << g);
               chk({tag, " result"}, bus.res, ref_gcd(p[g], q[g]));
               chk({tag, " err"}, bus.res_err, 0);
               served_idx.push_back(g);
               served_res.push_back(int'(bus.res));
               $display("%s: req%0d P=%0d Q=%0d -> res=%0d", tag, g, p[g], q[g], bus.res);
            end
         end
      end
      bus.req = 4'd0;
      chk({tag, " completed"}, {pending, 28'(exp_g.size())}, 0);
      chk({tag, " bypass kept engine idle"}, viol, 0);
   endtask

   typedef struct {
      int         idx;
      logic [7:0] p;
      logic [7:0] q;
      logic [7:0] exp_r;
      int         exp_lat;
      bit         exp_run;
   } vec_t;

   vec_t       vecs[8];
   int         a_lat, r_lat, ab, st, cnt;
   logic [3:0] m;
   logic [7:0] rr;
   logic       ee;
   logic [7:0] bp[4];
   logic [7:0] bq[4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // engine latency 2: result 6+L cycles after req; bypass 3 cycles
      vecs[0] = '{0,  48, 18,   6, 8, 1'b1};
      vecs[1] = '{1,   0, 35,  35, 3, 1'b0};
      vecs[2] = '{1,   0,  0,   0, 3, 1'b0};
      vecs[3] = '{2,  35, 21,   7, 8, 1'b1};
      vecs[4] = '{3,  17,  5,   1, 8, 1'b1};
      vecs[5] = '{2, 255, 17,  17, 8, 1'b1};
      vecs[6] = '{3, 100,  0, 100, 3, 1'b0};
      vecs[7] = '{0,   1,  1,   1, 8, 1'b1};

      bus.req   = 4'd0;
      bus.req_p = 32'd0;
      bus.req_q = 32'd0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset ack", bus.ack, 0);
      chk("reset res_valid", bus.res_valid, 0);
      chk("reset res", bus.res, 0);
      chk("reset res_err", bus.res_err, 0);
      chk("reset busy", bus.busy, 0);
      chk("reset eng_start", bus.eng_start, 0);
      chk("reset eng_p/q", {bus.eng_p, bus.eng_q}, 0);
      chk("reset eng_abort", bus.eng_abort, 0);
      rst = 1'b0;

      // stale done while idle must not start anything
      force_done = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.busy || bus.res_valid != 4'd0) cnt++;
      end
      force_done = 1'b0;
      chk("stale done in IDLE ignored", cnt, 0);
      repeat (2) @(posedge clk);
      #1;

      eng_lat = 2;
      for (int i = 0; i < 8; i++) begin
         do_job(vecs[i].idx, vecs[i].p, vecs[i].q, a_lat, r_lat, m, rr, ee, ab, st);
         chk("vec ack latency", a_lat, 1);
         chk("vec res_valid owner", m, 32'd1 << vecs[i].idx);
         chk("vec result", rr, vecs[i].exp_r);
         chk("vec err", ee, 0);
         chk("vec res latency", r_lat, vecs[i].exp_lat);
         chk("vec engine used", st > 0, vecs[i].exp_run);
         @(posedge clk); #1;
      end

      // contention: all four at once, round robin from req0 (ptr back at 0 after req3... force known)
      mptr = 1;
      do_job(0, 8'd2, 8'd4, a_lat, r_lat, m, rr, ee, ab, st);
      chk("pre-contention result", rr, 2);
      do_job(3, 8'd9, 8'd3, a_lat, r_lat, m, rr, ee, ab, st);
      chk("pre-contention result 2", rr, 3);
      bp = '{8'd12, 8'd9, 8'd35, 8'd17};
      bq = '{8'd8, 8'd6, 8'd21, 8'd5};
      run_batch(4'b1111, bp, bq, "contention");
      chk("contention count", served_idx.size(), 4);
      if (served_idx.size() == 4) begin
         chk("contention order", {8'(served_idx[0]), 8'(served_idx[1]), 8'(served_idx[2]), 8'(served_idx[3])}, 32'h00010203);
         chk("contention results", {8'(served_res[0]), 8'(served_res[1]), 8'(served_res[2]), 8'(served_res[3])}, 32'h04030701);
      end
      bp = '{8'd48, 8'd0, 8'd9, 8'd0};
      bq = '{8'd18, 8'd0, 8'd6, 8'd0};
      run_batch(4'b0101, bp, bq, "rerequest");
      chk("rerequest count", served_idx.size(), 2);
      if (served_idx.size() == 2) begin
         chk("rerequest order", {8'(served_idx[0]), 8'(served_idx[1])}, 16'h0002);
      end

      // engine hang -> timeout abort
      eng_hang = 1'b1;
      do_job(2, 8'd9, 8'd6, a_lat, r_lat, m, rr, ee, ab, st);
      eng_hang = 1'b0;
      chk("timeout abort cycle", ab, TMO);
      chk("timeout run cycles", st, TMO);
      chk("timeout owner", m, 4'b0100);
      chk("timeout result", rr, 0);
      chk("timeout err", ee, 1);
      chk("timeout res latency", r_lat, TMO + 3);

      // stale done held into REL
      eng_lat   = 1;
      eng_stale = 4;
      do_job(1, 8'd21, 8'd14, a_lat, r_lat, m, rr, ee, ab, st);
      chk("stale REL result", rr, 7);
      chk("stale REL latency", r_lat, 11);
      cnt = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.res_valid != 4'd0) cnt++;
      end
      chk("stale REL single pulse", cnt, 0);
      eng_stale = 0;

      // reset in the middle of a RUN job
      eng_lat = 10;
      bus.req_p[15:8] = 8'd48;
      bus.req_q[15:8] = 8'd18;
      bus.req = 4'b0010;
      a_lat = -1;
      for (int k = 1; k <= 5 && a_lat < 0; k++) begin
         @(posedge clk); #1;
         if (bus.ack != 4'd0) a_lat = k;
      end
      bus.req = 4'd0;
      chk("rstmid ack latency", a_lat, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("rstmid running", bus.eng_start, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstmid eng_start dropped", bus.eng_start, 0);
      chk("rstmid busy", bus.busy, 0);
      cnt = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus.res_valid != 4'd0) cnt++;
      end
      chk("rstmid no res_valid", cnt, 0);
      mptr    = 0;
      eng_lat = 2;
      bp = '{8'd0, 8'd30, 8'd0, 8'd45};
      bq = '{8'd0, 8'd12, 8'd0, 8'd25};
      run_batch(4'b1010, bp, bq, "after reset");
      do_job(3, 8'd48, 8'd36, a_lat, r_lat, m, rr, ee, ab, st);
      chk("post-reset req3 owner", m, 4'b1000);
      chk("post-reset req3 result", rr, 12);
      chk("post-reset req3 err", ee, 0);

      // random batches against the arithmetic model
      for (int b = 0; b < 12; b++) begin
         m = 4'($urandom_range(1, 15));
         eng_lat = $urandom_range(0, 6);
         for (int i = 0; i < 4; i++) begin
            bp[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            bq[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         end
         run_batch(m, bp, bq, "random");
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
